// File: rtl/axis_width_packer.sv
// AXI-Stream narrow-to-wide packer: folds WIDTH_N beats into WIDTH_W words
// in low-lane, high-lane, little-endian-pair or big-endian-pair mode.
module axis_width_packer #(
  parameter int unsigned WIDTH_N = 32,
  parameter int unsigned WIDTH_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cfg,
  input  logic [WIDTH_N-1:0] p_axis_data,
  input  logic               p_axis_valid,
  input  logic               p_axis_last,
  output logic               p_axis_ready,
  output logic [WIDTH_W-1:0] s_axis_data,
  output logic               s_axis_valid,
  output logic               s_axis_last,
  output logic [1:0]         s_axis_keep,
  input  logic               s_axis_ready,
  output logic               pair_pending
);

  generate
    if (WIDTH_W != 2 * WIDTH_N) begin : g_width_check
      $error("axis_width_packer: WIDTH_W must equal 2*WIDTH_N");
    end
  endgenerate

  localparam logic [1:0] CFG_LSB = 2'b00;
  localparam logic [1:0] CFG_MSB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HALF = 2'b01
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH_N-1:0] acc;
  logic               acc_be;

  logic               in_hs;
  logic               out_hs;
  logic               load_c;
  logic [WIDTH_W-1:0] ld_data_c;
  logic [1:0]         ld_keep_c;
  logic               ld_last_c;
  logic               acc_ld_c;

  assign p_axis_ready = !s_axis_valid || s_axis_ready;
  assign in_hs        = p_axis_valid && p_axis_ready;
  assign out_hs       = s_axis_valid && s_axis_ready;
  assign pair_pending = (state == HALF);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output-register load decode
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    ld_data_c = '0;
    ld_keep_c = 2'b00;
    ld_last_c = 1'b0;
    acc_ld_c  = 1'b0;
    case (state)
      IDLE: begin
        if (in_hs) begin
          case (cfg)
            CFG_LSB: begin
              load_c    = 1'b1;
              ld_data_c = {{WIDTH_N{1'b0}}, p_axis_data};
              ld_keep_c = 2'b01;
              ld_last_c = p_axis_last;
            end
            CFG_MSB: begin
              load_c    = 1'b1;
              ld_data_c = {p_axis_data, {WIDTH_N{1'b0}}};
              ld_keep_c = 2'b10;
              ld_last_c = p_axis_last;
            end
            default: begin
              if (p_axis_last) begin
                // Odd tail of a pair stream goes out alone in its natural lane
                load_c    = 1'b1;
                ld_last_c = 1'b1;
                if (cfg[0]) begin
                  ld_data_c = {p_axis_data, {WIDTH_N{1'b0}}};
                  ld_keep_c = 2'b10;
                end else begin
                  ld_data_c = {{WIDTH_N{1'b0}}, p_axis_data};
                  ld_keep_c = 2'b01;
                end
              end else begin
                acc_ld_c  = 1'b1;
                state_nxt = HALF;
              end
            end
          endcase
        end
      end
      HALF: begin
        if (in_hs) begin
          state_nxt = IDLE;
          load_c    = 1'b1;
          ld_keep_c = 2'b11;
          ld_last_c = p_axis_last;
          ld_data_c = acc_be ? {acc, p_axis_data} : {p_axis_data, acc};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // First-half accumulator and the pair order latched with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      acc_be <= 1'b0;
    end else if (acc_ld_c) begin
      acc    <= p_axis_data;
      acc_be <= cfg[0];
    end
  end

  // Output register; a load only happens when the slot is free or draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axis_valid <= 1'b0;
      s_axis_data  <= '0;
      s_axis_keep  <= 2'b00;
      s_axis_last  <= 1'b0;
    end else if (load_c) begin
      s_axis_valid <= 1'b1;
      s_axis_data  <= ld_data_c;
      s_axis_keep  <= ld_keep_c;
      s_axis_last  <= ld_last_c;
    end else if (out_hs) begin
      s_axis_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_width_packer.sv
// Scoreboard bench for axis_width_packer: directed cases plus random traffic
// with random output backpressure, checked against a beat-level reference model.
module tb_axis_width_packer;

  localparam int unsigned WN = 32;
  localparam int unsigned WW = 64;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [1:0]    keep;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg = 2'b00;
  logic [WN-1:0] p_axis_data = '0;
  logic          p_axis_valid = 1'b0;
  logic          p_axis_last = 1'b0;
  logic          p_axis_ready;
  logic [WW-1:0] s_axis_data;
  logic          s_axis_valid;
  logic          s_axis_last;
  logic [1:0]    s_axis_keep;
  logic          s_axis_ready = 1'b1;
  logic          pair_pending;

  int   vectors = 0;
  int   miscompares = 0;
  int   bp_mode = 0;   // 0: ready high, 1: ready low, 2: random
  exp_t q[$];

  // Reference model state: a held first half and its pair order
  bit            tb_pend = 1'b0;
  logic [WN-1:0] tb_acc = '0;
  bit            tb_be = 1'b0;

  axis_width_packer #(.WIDTH_N(WN), .WIDTH_W(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg          (cfg),
    .p_axis_data  (p_axis_data),
    .p_axis_valid (p_axis_valid),
    .p_axis_last  (p_axis_last),
    .p_axis_ready (p_axis_ready),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_keep  (s_axis_keep),
    .s_axis_ready (s_axis_ready),
    .pair_pending (pair_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Word(s) a beat produces, derived from the lane-mode rules
  task automatic model_beat(input logic [1:0] c, input logic [WN-1:0] d, input logic l);
    exp_t e;
    if (tb_pend) begin
      e.data  = tb_be ? {tb_acc, d} : {d, tb_acc};
      e.keep  = 2'b11;
      e.last  = l;
      tb_pend = 1'b0;
      q.push_back(e);
    end else if (c == 2'b00 || (c == 2'b10 && l)) begin
      e.data = {32'h0, d};
      e.keep = 2'b01;
      e.last = l;
      q.push_back(e);
    end else if (c == 2'b01 || (c == 2'b11 && l)) begin
      e.data = {d, 32'h0};
      e.keep = 2'b10;
      e.last = l;
      q.push_back(e);
    end else begin
      tb_pend = 1'b1;
      tb_acc  = d;
      tb_be   = c[0];
    end
  endtask

  // Called and returns at posedge+1
  task automatic send(input logic [1:0] c, input logic [WN-1:0] d, input logic l,
                      output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    cfg = c;
    p_axis_data = d;
    p_axis_last = l;
    p_axis_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      chk("pair_pending", 128'(pair_pending), 128'(tb_pend));
      if (p_axis_ready) begin
        model_beat(c, d, l);
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          vectors++;
          miscompares++;
          $display("FAIL accept_timeout: beat %0h not accepted after %0d cycles", d, stalls);
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;
    p_axis_valid = 1'b0;
    p_axis_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_pair_pending", 128'(pair_pending), 128'(tb_pend));
      @(posedge clk);
      #1;
    end
  endtask

  // Output-ready driver
  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0:       s_axis_ready = 1'b1;
      1:       s_axis_ready = 1'b0;
      default: s_axis_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: scoreboard pops, ready rule, and stability under backpressure
  bit   stall_prev = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      chk("p_axis_ready", 128'(p_axis_ready), 128'(!s_axis_valid || s_axis_ready));
      if (stall_prev)
        chk("hold_stable", 128'({s_axis_valid, s_axis_data, s_axis_keep, s_axis_last}),
            128'({1'b1, held}));
      if (s_axis_valid && s_axis_ready) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %0h keep %0b last %0b, expected none",
                   s_axis_data, s_axis_keep, s_axis_last);
        end else begin
          e = q.pop_front();
          chk("word", 128'({s_axis_data, s_axis_keep, s_axis_last}), 128'(e));
        end
      end
      stall_prev = s_axis_valid && !s_axis_ready;
      held = '{data: s_axis_data, keep: s_axis_keep, last: s_axis_last};
    end
  end

  initial begin
    int st;
    int tot;
    #1;
    chk("rst_valid", 128'(s_axis_valid), 128'(0));
    chk("rst_data", 128'({s_axis_data, s_axis_keep, s_axis_last}), 128'(0));
    chk("rst_pair_pending", 128'(pair_pending), 128'(0));
    chk("rst_p_ready", 128'(p_axis_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // LE pair with latency check
    send(2'b10, 32'h11111111, 1'b0, st);
    send(2'b10, 32'h22222222, 1'b1, st);
    chk("le_latency_valid", 128'(s_axis_valid), 128'(1));
    idle(2);
    // BE pair
    send(2'b11, 32'h11111111, 1'b0, st);
    send(2'b11, 32'h22222222, 1'b1, st);
    idle(2);
    // single lanes
    send(2'b00, 32'hA5A5A5A5, 1'b1, st);
    send(2'b01, 32'hA5A5A5A5, 1'b1, st);
    // odd tails
    send(2'b10, 32'hDEADBEEF, 1'b1, st);
    send(2'b11, 32'hCAFEF00D, 1'b1, st);
    idle(2);

    // throughput: 8 back-to-back beats, no input stall
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'b10, 32'(i), 1'(i == 7), st);
      tot += st;
    end
    chk("throughput_stalls", 128'(tot), 128'(0));
    idle(2);

    // backpressure with a pending word, then release
    bp_mode = 1;
    idle(1);
    send(2'b10, 32'h8, 1'b0, st);
    send(2'b10, 32'h9, 1'b1, st);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_p_ready_low", 128'(p_axis_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    bp_mode = 0;
    send(2'b00, 32'hA, 1'b0, st);
    send(2'b01, 32'hB, 1'b1, st);
    idle(3);

    // cfg change between halves keeps the latched LE order
    send(2'b10, 32'h0000AAAA, 1'b0, st);
    send(2'b11, 32'h0000BBBB, 1'b1, st);
    idle(2);

    // reset while in HALF
    send(2'b10, 32'h55555555, 1'b0, st);
    rst = 1'b1;
    #1;
    chk("rst_mid_pair_pending", 128'(pair_pending), 128'(0));
    chk("rst_mid_valid", 128'(s_axis_valid), 128'(0));
    tb_pend = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(2'b10, 32'h3, 1'b0, st);
    send(2'b10, 32'h4, 1'b1, st);
    idle(2);

    // random traffic under random backpressure
    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 3) == 0), st);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    bp_mode = 0;
    idle(10);
    chk("scoreboard_drained", 128'(q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_width_packer.md
Name: axis_width_packer

Overview:
- Single-clock AXI-Stream upsizer. Packs narrow WIDTH_N beats into wide WIDTH_W words.
- Four lane modes, selected by cfg: low-lane only, high-lane only, little-endian pair, big-endian pair.
- Sits on the receive path, upstream of wide consumers. It is the reassembly counterpart of the wide-to-narrow splitter feeding the async FIFO.
- One accumulator register plus one output register give full narrow-beat throughput.

Parameters:
- WIDTH_N, 32, narrow input data width.
- WIDTH_W, 64, wide output data width. Must equal 2*WIDTH_N; an elaboration-time check fails otherwise.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg  in  2  lane mode: 00 LSB, 01 MSB, 10 LITTLE_ENDIAN, 11 BIG_ENDIAN.
- p_axis_data  in  WIDTH_N  narrow input data.
- p_axis_valid  in  1  input valid.
- p_axis_last  in  1  input end-of-packet.
- p_axis_ready  out  1  input ready.
- s_axis_data  out  WIDTH_W  wide output data.
- s_axis_valid  out  1  output valid.
- s_axis_last  out  1  output end-of-packet.
- s_axis_keep  out  2  half-lane valid flags; bit0 = low half, bit1 = high half.
- s_axis_ready  in  1  output ready.
- pair_pending  out  1  high while a first half is held in the accumulator.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high, rst. On rst:
  - state = IDLE, accumulator and latched pair mode cleared.
  - s_axis_valid/last/data/keep = 0, pair_pending = 0.
  - p_axis_ready therefore reads 1.
- Handshakes: in_hs = p_axis_valid & p_axis_ready; out_hs = s_axis_valid & s_axis_ready.
- Ready: p_axis_ready = !s_axis_valid | s_axis_ready. Combinational, does not depend on p_axis_valid.
- Output register: loaded on the cycle of a completing in_hs; s_axis_valid rises on the next edge (1-cycle latency).
  - With s_axis_valid=1 and s_axis_ready=0, data/last/keep hold stable.
  - On out_hs with no new load, s_axis_valid goes to 0; if a new load coincides with out_hs, the register reloads and valid stays 1.
  - Unused output half is driven to zero.
- cfg is sampled only on an in_hs in IDLE; in HALF it is ignored.
- FSM states: IDLE, HALF.
- IDLE, in_hs:
  - cfg=00: load {0, d}, keep=01, last=p_axis_last; stay IDLE.
  - cfg=01: load {d, 0}, keep=10, last=p_axis_last; stay IDLE.
  - cfg=10/11, p_axis_last=0: store d in accumulator, latch LE/BE, no output load; go to HALF.
  - cfg=10/11, p_axis_last=1 (odd tail): emit immediately with last=1; stay IDLE.
    - LE: {0, d}, keep=01.
    - BE: {d, 0}, keep=10.
- HALF, in_hs: go to IDLE; last = p_axis_last of this second beat.
  - LE: load {d, acc}, keep=11.
  - BE: load {acc, d}, keep=11.
- HALF without in_hs: hold indefinitely; no timeout, no flush.
- pair_pending = (state == HALF).
- Throughput: with s_axis_ready=1, one narrow beat accepted every cycle. Pair modes yield one wide word per two beats; LSB/MSB modes yield one per beat.
- Reset mid-pair or mid-backpressure: held half and pending output are discarded silently; the next beat after reset starts a fresh word.
- Unknown/illegal states recover to IDLE.

Test Plan:
- LE pair: cfg=10, beats 0x11111111 (last=0) then 0x22222222 (last=1), s_axis_ready=1 -> one word 0x22222222_11111111, keep=11, last=1. Valid appears 1 cycle after the 2nd handshake; pair_pending high for exactly one cycle.
- BE pair: same beats with cfg=11 -> 0x11111111_22222222, keep=11, last=1.
- Single lanes: cfg=00, beat 0xA5A5A5A5 last=1 -> 0x00000000_A5A5A5A5, keep=01. Then cfg=01, same beat -> 0xA5A5A5A5_00000000, keep=10.
- Odd tail: cfg=10, IDLE, beat 0xDEADBEEF last=1 -> 0x00000000_DEADBEEF, keep=01, last=1; pair_pending never rises.
- Backpressure/throughput: cfg=10, 8 back-to-back beats 0..7 with s_axis_ready=1 -> words {1,0},{3,2},{5,4},{7,6} with no input stall.
  - Then hold s_axis_ready=0 for 5 cycles with a word pending -> p_axis_ready=0 and output stable throughout.
  - On release, no beat is lost or duplicated.
- cfg change and reset: cfg switched 10->11 between halves -> pair still packed LE.
  - Assert rst while in HALF -> pair_pending=0 and s_axis_valid=0 immediately.
  - After release, beats 0x3,0x4 (cfg=10) -> 0x00000004_00000003.
